// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every N_IN-bit input vector in ascending
// order, holds each for DWELL cycles, and scores the DUT response against EXP_TT.
module truth_table_sweeper #(
    parameter int                      N_IN   = 4,
    parameter int                      DWELL  = 1,
    parameter logic [(1<<N_IN)-1:0]    EXP_TT = 16'hA5C3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int              CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   LAST_DWELL = CW'(DWELL - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE    = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   dwell_cnt, dwell_nxt;
    logic [N_IN-1:0] stim_nxt;
    logic            busy_nxt, done_nxt, pass_nxt;
    logic [N_IN:0]   err_nxt;
    logic [N_IN-1:0] first_vec_nxt;
    logic            first_valid_nxt;

    logic sample;
    logic mismatch;

    assign sample   = (dwell_cnt == LAST_DWELL);
    assign mismatch = (resp != EXP_TT[stim]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            dwell_cnt       <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            dwell_cnt       <= dwell_nxt;
            stim            <= stim_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            err_count       <= err_nxt;
            first_err_vec   <= first_vec_nxt;
            first_err_valid <= first_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        dwell_nxt       = dwell_cnt;
        stim_nxt        = stim;
        busy_nxt        = busy;
        done_nxt        = done;
        pass_nxt        = pass;
        err_nxt         = err_count;
        first_vec_nxt   = first_err_vec;
        first_valid_nxt = first_err_valid;

        // abort outranks start in every state; scoring results are kept
        if (abort) begin
            state_nxt = IDLE;
            dwell_nxt = '0;
            stim_nxt  = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            pass_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt       = APPLY;
                        dwell_nxt       = '0;
                        stim_nxt        = '0;
                        busy_nxt        = 1'b1;
                        done_nxt        = 1'b0;
                        pass_nxt        = 1'b0;
                        err_nxt         = '0;
                        first_vec_nxt   = '0;
                        first_valid_nxt = 1'b0;
                    end
                end
                APPLY: begin
                    dwell_nxt = dwell_cnt + CNT_ONE;
                    if (sample) begin
                        if (mismatch) begin
                            err_nxt = err_count + ERR_ONE;
                            if (!first_err_valid) begin
                                first_vec_nxt   = stim;
                                first_valid_nxt = 1'b1;
                            end
                        end
                        dwell_nxt = '0;
                        if (stim == LAST_VEC) begin
                            state_nxt = DONE;
                            stim_nxt  = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            // the final sample's own verdict must count toward pass
                            pass_nxt  = !mismatch && (err_count == '0);
                        end else begin
                            stim_nxt = stim + VEC_ONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven and random fault masks on the
// default 4-input build, plus latency/dwell builds and control corner cases.
module tb_truth_table_sweeper;

    localparam logic [15:0] TT_MAIN = 16'hA5C3;
    localparam logic [7:0]  TT3     = 8'h96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // default build: combinational DUT whose response is TT_MAIN with chosen bits flipped
    logic        start, abort, resp;
    logic [3:0]  stim;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_vec;
    logic        first_err_valid;
    logic [15:0] fault_mask;

    assign resp = TT_MAIN[stim] ^ fault_mask[stim];

    truth_table_sweeper u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .resp(resp),
        .stim(stim), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    // 3-input builds driving a DUT with two register stages of latency
    logic       start3, abort3, resp3, busy3, done3, pass3, fev3;
    logic [2:0] stim3, fv3;
    logic [3:0] err3;
    logic       start2, abort2, resp2, busy2, done2, pass2, fev2;
    logic [2:0] stim2, fv2;
    logic [3:0] err2;
    logic       p3_a, p3_b, p2_a, p2_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3_a <= 1'b0; p3_b <= 1'b0; p2_a <= 1'b0; p2_b <= 1'b0;
        end else begin
            p3_a <= TT3[stim3]; p3_b <= p3_a;
            p2_a <= TT3[stim2]; p2_b <= p2_a;
        end
    end
    assign resp3 = p3_b;
    assign resp2 = p2_b;

    truth_table_sweeper #(.N_IN(3), .DWELL(3), .EXP_TT(8'h96)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .resp(resp3),
        .stim(stim3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_vec(fv3), .first_err_valid(fev3)
    );

    truth_table_sweeper #(.N_IN(3), .DWELL(2), .EXP_TT(8'h96)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .resp(resp2),
        .stim(stim2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_vec(fv2), .first_err_valid(fev2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: what the DUT answers for vector v, and the sweep verdict derived from it
    function automatic logic model_resp(input logic [15:0] mask, input int v);
        logic [15:0] tt;
        tt = TT_MAIN ^ mask;
        return tt[v];
    endfunction

    task automatic model_sweep(input logic [15:0] mask, output int e, output int f, output int fv);
        e = 0; f = 0; fv = 0;
        for (int v = 0; v < 16; v++) begin
            if (model_resp(mask, v) != TT_MAIN[v]) begin
                e++;
                if (fv == 0) begin
                    f  = v;
                    fv = 1;
                end
            end
        end
    endtask

    task automatic check_main_outputs(input string tag, input int e, input int f, input int fv,
                                      input int d, input int p);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_stim"}, stim, 0);
        check({tag, "_done"}, done, d);
        check({tag, "_pass"}, pass, p);
        check({tag, "_err_count"}, err_count, e);
        check({tag, "_first_vec"}, first_err_vec, f);
        check({tag, "_first_valid"}, first_err_valid, fv);
    endtask

    // One full sweep of the default build; poke_at >= 0 pulses start mid-sweep
    task automatic sweep_main(input logic [15:0] mask, input int e, input int f, input int fv,
                              input int poke_at, input string tag);
        fault_mask = mask;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_stim_k%0d", tag, k), stim, k);
            check($sformatf("%s_busy_k%0d", tag, k), busy, 1);
            check($sformatf("%s_done_k%0d", tag, k), done, 0);
            if (k == poke_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check_main_outputs(tag, e, f, fv, 1, (e == 0) ? 1 : 0);
    endtask

    typedef struct {
        logic [15:0] mask;
        int          err;
        int          first;
        int          valid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int e, f, fv, cyc;
        logic [15:0] m;

        vecs[0] = '{16'h0000, 0, 0, 0};
        vecs[1] = '{16'h0200, 1, 9, 1};
        vecs[2] = '{16'hFFFF, 16, 0, 1};
        vecs[3] = '{16'h8000, 1, 15, 1};
        vecs[4] = '{16'h0001, 1, 0, 1};
        vecs[5] = '{16'h00F0, 4, 4, 1};

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; fault_mask = '0;
        start3 = 1'b0; abort3 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        #2;
        check_main_outputs("reset", 0, 0, 0, 0, 0);
        check("reset_busy3", busy3, 0);
        check("reset_stim3", stim3, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            sweep_main(vecs[i].mask, vecs[i].err, vecs[i].first, vecs[i].valid, -1,
                       $sformatf("tbl%0d", i));

        for (int r = 0; r < 6; r++) begin
            m = 16'($urandom);
            if (r == 0) m = 16'($urandom_range(1, 3)) << 13;
            model_sweep(m, e, f, fv);
            sweep_main(m, e, f, fv, -1, $sformatf("rnd%0d", r));
        end

        // start while sweeping is ignored
        sweep_main(16'h0000, 0, 0, 0, 5, "start_ignored");

        // abort at stim 7 keeps the partial score and parks in IDLE
        fault_mask = 16'h0008;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_pre_stim", stim, 7);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_main_outputs("abort_apply", 1, 3, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("abort_idle_stim", stim, 0);
        check("abort_idle_busy", busy, 0);
        sweep_main(16'h0000, 0, 0, 0, -1, "after_abort");

        // start and abort together in DONE: abort wins, results retained
        sweep_main(16'h0020, 1, 5, 1, -1, "pre_both");
        start = 1'b1; abort = 1'b1;
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check_main_outputs("both_done", 1, 5, 1, 0, 0);
        @(negedge clk);
        check("both_still_idle", busy, 0);

        // abort alone in DONE
        sweep_main(16'h0001, 1, 0, 1, -1, "pre_abort_done");
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_main_outputs("abort_done", 1, 0, 1, 0, 0);

        // asynchronous reset in the middle of a cycle
        fault_mask = 16'h0004;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_pre_stim", stim, 10);
        check("rst_pre_err", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check_main_outputs("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        sweep_main(16'h0000, 0, 0, 0, -1, "post_rst");

        // latency DUT with enough dwell
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check($sformatf("d3_stim_k%0d", k), stim3, k / 3);
            check($sformatf("d3_busy_k%0d", k), busy3, 1);
            check($sformatf("d3_done_k%0d", k), done3, 0);
            @(negedge clk);
        end
        check("d3_done", done3, 1);
        check("d3_pass", pass3, 1);
        check("d3_err", err3, 0);
        check("d3_first_valid", fev3, 0);

        // same DUT with too little dwell must see errors
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("d2_done_cycles", cyc, 16);
        check("d2_err_nonzero", (err2 != 0) ? 1 : 0, 1);
        check("d2_pass", pass2, 0);
        check("d2_first_valid", fev2, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking exhaustive stimulus engine for an N_IN-input, single-output combinational DUT.
- On start, drives all 2^N_IN input vectors in ascending binary order and holds each for DWELL cycles.
- Samples the DUT response at the end of each window and compares it against a parameterised expected truth table.
- Reports the mismatch count, the first failing vector, and pass/done status. Used in lab benches and on-board self-test in place of hand-written vector lists.

Parameters:
- N_IN, 4, number of DUT inputs (1..8).
- DWELL, 1, cycles each vector is held before sampling (≥1; covers DUT latency).
- EXP_TT, 16'hA5C3, expected truth table, width 2^N_IN; bit v is the expected response to stim==v.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a sweep when in IDLE or DONE.
- abort  input  1  one-cycle pulse; cancels a sweep and returns to IDLE.
- resp  input  1  DUT output.
- stim  output  N_IN  vector driven to the DUT.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE until next start/abort.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors in the current/last sweep.
- first_err_vec  output  N_IN  stim value of the first mismatch.
- first_err_valid  output  1  first_err_vec holds a captured value.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE. All outputs 0: stim, busy, done, pass, err_count, first_err_vec, first_err_valid.
- States: IDLE, APPLY, DONE.
- IDLE→APPLY on start.
  - Same edge: stim←0, dwell counter←0, err_count←0, first_err_valid←0, first_err_vec←0, done←0, pass←0, busy←1.
- APPLY: stim holds vector v for exactly DWELL cycles. The dwell counter increments each edge.
- Sample edge is the edge where dwell counter==DWELL-1:
  - resp compared with EXP_TT[v].
  - On mismatch: err_count+1. If first_err_valid==0, first_err_vec←v and first_err_valid←1.
  - If v<2^N_IN-1: stim←v+1 and dwell counter←0.
  - If v==2^N_IN-1: →DONE, busy←0, done←1, pass←(final err_count==0, including this sample), stim←0.
- Sweep length: first vector appears the cycle after start. done rises exactly 2^N_IN·DWELL cycles after the start edge.
- DONE: outputs held; start→restart exactly as from IDLE. abort→IDLE with done←0, pass←0; err_count and first_err_* retained.
- abort in APPLY: →IDLE next edge, busy←0, stim←0, done←0. Counters keep their partial values.
- start while in APPLY: ignored.
- start and abort in the same cycle: abort wins.
- rst_n low at any time, including mid-sweep: immediate return to reset values with no partial results kept.
- resp is sampled only on sample edges; values on other cycles are don't-care.
- err_count maximum is 2^N_IN, which fits in N_IN+1 bits, so no saturation logic is needed.
- stim wraps never; the sweep ends at all-ones.

Test Plan:
- Matching DUT, defaults (DUT model returns EXP_TT[stim], 16'hA5C3), pulse start → stim 0..15 one per cycle; done at cycle 16 after start; pass=1, err_count=0, first_err_valid=0.
- Single fault: DUT inverts response only for stim=4'b1001 → err_count=1, first_err_vec=9, first_err_valid=1, pass=0.
- Fully inverted DUT → err_count=16 (5'b10000), first_err_vec=0, pass=0.
- DWELL=3, N_IN=3, EXP_TT=8'h96, DUT with 2-cycle registered latency → each stim held 3 cycles; done 24 cycles after start; pass=1. The same DUT with DWELL=2 → err_count>0.
- Control edge cases:
  - Start pulse at stim=5 is ignored, and the sweep completes normally.
  - abort at stim=7 → IDLE next cycle; busy=0, stim=0, done=0.
  - A new start → full sweep, with counters cleared.
- Async reset: assert rst_n=0 mid-cycle at stim=10 → all outputs 0 immediately, without waiting for a clock edge. After release, start → full clean sweep.
